// File: rtl/my_mux8way_arb.sv
// 8-to-1 valid/ready stream merger with round-robin arbitration.
// One registered output stage; each word is tagged with its source channel index.
module my_mux8way_arb #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [2:0]       out_sel_reg, out_sel_next;
  logic [2:0]       lg_reg, lg_next;

  logic             load;
  logic             accept;
  logic             grant_valid;
  logic [2:0]       grant;
  logic [2:0]       offset;
  logic [7:0]       rot_valid;
  logic [2:0]       rot_idx [8];
  logic [WIDTH-1:0] ch_word [8];

  // The output register can take a new word when empty or being drained now.
  assign load = !out_valid_reg || out_ready;

  // rot_valid[k] is the channel searched at step k+1 after the last grant.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      assign rot_idx[gi]   = lg_reg + 3'(gi + 1);
      assign rot_valid[gi] = in_valid[rot_idx[gi]];
      assign ch_word[gi]   = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Lowest set bit of the rotated request vector wins.
  always_comb begin
    grant_valid = 1'b0;
    offset      = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_valid[i]) begin
        grant_valid = 1'b1;
        offset      = 3'(i);
      end
    end
  end

  assign grant  = lg_reg + offset + 3'd1;
  assign accept = load && grant_valid && !reset;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ready
      assign in_ready[gi] = accept && (grant == 3'(gi));
    end
  endgenerate

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    lg_next        = lg_reg;
    if (accept) begin
      out_valid_next = 1'b1;
      out_data_next  = ch_word[grant];
      out_sel_next   = grant;
      lg_next        = grant;
    end else if (load) begin
      // Drained with nothing to refill: data and sel keep stale values.
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= 3'd0;
      lg_reg        <= 3'd7;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      lg_reg        <= lg_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_my_mux8way_arb.sv
// Bench for my_mux8way_arb: directed scenarios plus random traffic, with a
// search-order reference model feeding a scoreboard checked by a separate monitor.
module tb_my_mux8way_arb;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     in_valid = 8'h00;
  logic [8*W-1:0] in_data = '0;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready = 1'b0;

  my_mux8way_arb #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   sel;
    logic [W-1:0] data;
  } exp_t;

  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q[$];
  logic [W-1:0] ch_data [8];
  logic [7:0] cur_valid = 8'h00;
  int         m_lg = 7;
  bit         m_ov = 1'b0;

  // One clock: drive after the edge, check and advance the model mid-cycle.
  task automatic cycle(input bit rst, input bit ordy, input bit drop);
    int         g;
    bit         found;
    bit         m_load;
    logic [7:0] exp_rdy;
    @(posedge clk); #1;
    reset     = rst;
    out_ready = ordy;
    in_valid  = cur_valid;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = ch_data[i];
    @(negedge clk);
    found = 1'b0;
    g     = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!found && cur_valid[(m_lg + k) % 8]) begin
        found = 1'b1;
        g     = (m_lg + k) % 8;
      end
    end
    m_load  = !m_ov || ordy;
    exp_rdy = (!rst && m_load && found) ? 8'(1 << g) : 8'h00;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %h expected %h (rst=%0d lg=%0d valid=%h)",
               in_ready, exp_rdy, rst, m_lg, cur_valid);
    end
    checks++;
    if (out_valid !== m_ov) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
    end
    if (rst) begin
      exp_q.delete();
      m_ov = 1'b0;
      m_lg = 7;
    end else if (m_load) begin
      if (found) begin
        exp_q.push_back('{sel: 3'(g), data: ch_data[g]});
        $display("accept ch%0d data=%h", g, ch_data[g]);
        m_ov = 1'b1;
        m_lg = g;
        if (drop) cur_valid[g] = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  // Monitor: every word the consumer takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin : mon
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL output: unexpected word sel=%0d data=%h", out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_sel !== e.sel || out_data !== e.data) begin
          errors++;
          $display("FAIL output: got sel=%0d data=%h expected sel=%0d data=%h",
                   out_sel, out_data, e.sel, e.data);
        end else begin
          $display("out sel=%0d data=%h", out_sel, out_data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) ch_data[i] = '0;

    // Reset with every channel requesting: no in_ready.
    cur_valid = 8'hFF;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (out_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset out_sel: got %0d expected 0", out_sel);
    end
    cur_valid = 8'h00;
    cycle(1'b0, 1'b1, 1'b1);

    // Single channel 5.
    cur_valid  = 8'h20;
    ch_data[5] = 16'h1234;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);

    // Full round-robin from a fresh reset.
    cycle(1'b1, 1'b1, 1'b1);
    cur_valid = 8'hFF;
    for (int i = 0; i < 8; i++) ch_data[i] = 16'h00A0 + 16'(i);
    for (int n = 0; n < 9; n++) cycle(1'b0, 1'b1, 1'b0);
    cur_valid = 8'h00;
    cycle(1'b0, 1'b1, 1'b1);

    // Wrap-around after a channel-6 transfer.
    cur_valid  = 8'h40;
    ch_data[6] = 16'h0606;
    cycle(1'b0, 1'b1, 1'b1);
    cur_valid  = 8'h44;
    ch_data[2] = 16'h0202;
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b0);
    cur_valid = 8'h00;
    cycle(1'b0, 1'b1, 1'b1);

    // Backpressure holding a channel-3 word, then refill from channel 7.
    cur_valid  = 8'h08;
    ch_data[3] = 16'hBEEF;
    cycle(1'b0, 1'b1, 1'b1);
    cur_valid  = 8'h81;
    ch_data[0] = 16'h1111;
    ch_data[7] = 16'h7777;
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cur_valid = 8'h00;
    cycle(1'b0, 1'b1, 1'b1);

    // Reset in the middle of full traffic.
    cur_valid = 8'hFF;
    for (int i = 0; i < 8; i++) ch_data[i] = 16'hC000 + 16'(i);
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 2; n++) cycle(1'b0, 1'b1, 1'b0);
    cur_valid = 8'h00;
    cycle(1'b0, 1'b1, 1'b1);

    // Random traffic: sources hold words until accepted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (!cur_valid[i] && $urandom_range(0, 2) == 0) begin
          cur_valid[i] = 1'b1;
          ch_data[i]   = W'($urandom);
        end
      end
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'b1);
    end

    cur_valid = 8'h00;
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words never delivered, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/my_mux8way_arb.md
Name: my_mux8way_arb

Overview:
- 8-to-1 stream merger: collects words from eight valid/ready source channels onto one registered output channel.
- Uses a round-robin arbiter.
- Tags each output word with its 3-bit source index, so a downstream demux stage can route responses back using the same select encoding (sel 0..7 ↔ channel 0..7).
- Sits in front of any shared single-port consumer fed by eight producers.

Parameters:
- WIDTH, 16, data width of each channel in bits (must be ≥1).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 8, bit i = channel i presenting a word.
- in_data, input, 8*WIDTH, channel i word at bits [i*WIDTH +: WIDTH].
- in_ready, output, 8, bit i = channel i word accepted this cycle (one-hot or zero).
- out_valid, output, 1, output word held and valid.
- out_data, output, WIDTH, merged output word.
- out_sel, output, 3, source channel index of out_data.
- out_ready, input, 1, consumer accepts out_data this cycle.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset effects:
  - out_valid=0, out_data=0, out_sel=0.
  - Internal last-grant register lg=7, so channel 0 has top priority first.
  - While reset is high, in_ready=8'h00 combinationally.
- Load enable: load = !out_valid || out_ready. The output register is free, or is being drained this cycle.
- Arbitration, combinational:
  - Search in_valid in order lg+1, lg+2, …, lg+8, indices taken mod 8.
  - The first set bit is the grant g.
  - If no bit is set, there is no grant.
- in_ready[i] = load && grant_valid && (g==i) && !reset. At most one bit is set; in_ready may depend combinationally on in_valid and out_ready.
- Transfer on channel i: in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data ← channel i word, out_sel ← i, out_valid ← 1, lg ← i.
  - Latency is 1 cycle from accept to out_valid.
- load=1 with no valid input: out_valid ← 0 on the edge. out_data and out_sel hold their old values; they are don't-care while out_valid=0. lg is unchanged.
- Backpressure:
  - out_valid=1 && out_ready=0 → load=0, in_ready=0.
  - out_data, out_sel and lg hold unchanged.
- Simultaneous drain and refill (out_valid && out_ready with a new grant): the new word replaces the old in the same edge, giving full throughput of 1 word/cycle.
- Source protocol: a source keeps in_valid and in_data stable until accepted. The block does not buffer unaccepted words. A source that deasserts valid early simply loses arbitration; this causes no error.
- lg only updates on a transfer. Idle cycles do not rotate priority.
- Fairness: a continuously valid channel is granted within 8 transfers.
- Wrap-around: lg=7 → channel 0 is searched first. lg=i with only channel i valid → i is granted again.
- Reset asserted mid-stream: on that edge out_valid → 0 and lg → 7. Any word in the output register is discarded. No in_ready is asserted during the reset cycle.
- The output register is the only data storage, so depth is 1. There is no combinational path from in_data to out_data.

Test Plan:
1. Reset: hold reset 2 cycles with in_valid=8'hFF → in_ready=8'h00 throughout. After release: out_valid=0, out_sel=0.
2. Single channel: in_valid=8'h20, ch5=16'h1234, out_ready=1 → in_ready=8'h20 that cycle. Next cycle: out_valid=1, out_data=16'h1234, out_sel=5.
3. Round-robin: in_valid=8'hFF held, out_ready=1, ch i data=16'h00A0+i → out_sel sequence 0,1,2,…,7,0 on consecutive cycles with matching data, no bubbles.
4. Wrap: lg=6 (after a channel-6 transfer), in_valid=8'h44 → grant ch2, next cycle out_sel=2. Then grant ch6, then ch2.
5. Backpressure: out_valid=1 (sel=3, data=16'hBEEF), out_ready=0 for 4 cycles, in_valid=8'h81 → in_ready=0, output held. On out_ready=1 the same edge loads ch7 (lg=3 search order 4..7,0..3) → out_sel=7.
6. Mid-stream reset: traffic on all channels, assert reset for 1 cycle → out_valid=0 next cycle. First post-reset grant is channel 0.
